alu_control_sequencer: RTL and testbench
========================================

# alu_control_sequencer

Control unit that drives the datapath's register-transfer strobes for register-to-register ALU instructions. It fetches an instruction through the PC/MAR/MDR path, decodes the IR fields, and steps through T-states, asserting the same control strobes the datapath testbenches drive by hand (PCout, MARin, IncPC, Zlowin, R*in/R*out, ALU op select, …). It sits directly upstream of the datapath: its outputs connect to the datapath's control inputs, and its `ir` input is the datapath's IR register.

## Interface
- `RESET_PC_HOLD`, default 0: when 1, the first fetch after `clear` is delayed until `run` is 1.

Ports:
- `clock` in 1: single clock; everything is rising-edge.
- `clear` in 1: synchronous reset, active-high.
- `run` in 1: level enable. When 0, the sequencer parks in IDLE at the next instruction boundary.
- `ir` in 32: datapath IR. Fields: opcode = [31:27], Ra = [26:23], Rb = [22:19], Rc = [18:15].
- `mem_rdy` in 1: memory data on Mdatain is valid this cycle.
- `PCout, MARin, IncPC, PCin` out 1 each: fetch strobes.
- `MDMuxread, MDRin, MDRout, IRin` out 1 each: memory/IR strobes.
- `Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin` out 1 each: ALU staging strobes.
- `Rin` out 16: one-hot register write enables, bit n maps to Rn.
- `Rout` out 16: one-hot register output enables.
- `ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT` out 1 each: ALU op, at most one high.
- `done` out 1: one-cycle pulse in the last T-state of a completed instruction.
- `illegal_op` out 1: one-cycle pulse when an unsupported opcode is decoded.
- `tstate` out 4: current state encoding, for debug and bench only.

## Operation
- Moore FSM. All outputs are decoded combinationally from the state register and the registered `ir`. Any strobe not listed for a state is 0.
- States: IDLE(0), T0(1), T1(2), T1M(3), T2(4), T3(5), T4(6), T5(7), T6(8).
- Supported opcodes:
  - Three-register: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011.
  - Two-register HI/LO: div 01111, mul 10000.
  - Unary: neg 10001, not 10010.
- IDLE: no strobes. Go to T0 when `run` = 1.
- T0: PCout, MARin, IncPC, Zlowin. Next state T1.
- T1: Zlowout, PCin. Next state T1M.
- T1M: MDMuxread held high. MDRin = `mem_rdy`. Stay in T1M while `mem_rdy` = 0; go to T2 when it is 1.
- T2: MDRout, IRin. Next state T3.
- T3 decodes the opcode:
  - Three-register: Rout[Rb], Yin.
  - mul/div: Rout[Ra], Yin.
  - neg/not: Rout[Rb], op strobe, Zlowin.
  - Illegal: illegal_op only, next state T0 (or IDLE if `run` = 0).
- T4:
  - Three-register: Rout[Rc], op strobe, Zlowin.
  - mul/div: Rout[Rb], op strobe, Zlowin, Zhighin.
  - neg/not: Zlowout, Rin[Ra], done.
- T5:
  - Three-register: Zlowout, Rin[Ra], done.
  - mul/div: Zlowout, LOin.
- T6 (mul/div only): Zhighout, HIin, done.
- After a state that asserts done, the next state is T0 if `run` = 1, else IDLE.
- `run` is sampled only at instruction boundaries. Deasserting it mid-instruction does not abort the instruction.
- Register fields are 4 bits, so Rin/Rout decode to exactly one hot bit. Ra = Rb is legal.

## Timing
- On `clear`, the next state is IDLE and every output is 0 (`tstate` = 0). `clear` overrides `mem_rdy` and `run` in the same cycle.
- `clear` asserted mid-instruction abandons the instruction; no done and no further strobes.
- Each strobe is high for the whole state cycle. The datapath captures it on the rising edge that ends the state.
- Latency from leaving IDLE (memory with no wait, `mem_rdy` = 1 in T1M), counting to the done cycle inclusive:
  - neg/not: 6 cycles.
  - Three-register: 7 cycles.
  - mul/div: 8 cycles.
- Each cycle with `mem_rdy` = 0 in T1M adds one cycle.
- Back-to-back instructions with `run` held high leave no idle cycles: done is followed directly by T0.
- `done` and `illegal_op` are never high in the same cycle.

## Test plan
- NOT R6,R7: `ir` = 32'h93380000, `mem_rdy` = 1.
  - T3: Rout = 16'h0080, NOT = 1, Zlowin = 1.
  - T4: Rin = 16'h0040, Zlowout = 1, done = 1.
  - 6 cycles total.
- ADD R1,R2,R3: `ir` = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}.
  - T3: Rout = 16'h0004, Yin = 1.
  - T4: Rout = 16'h0008, ADD = 1.
  - T5: Rin = 16'h0002, done = 1.
- MUL R4,R5: T4 shows MUL, Zlowin and Zhighin high. T5 shows LOin, T6 shows HIin and done. 8 cycles total.
- Memory wait: hold `mem_rdy` = 0 for 3 cycles in T1M.
  - FSM stays in T1M (`tstate` = 3) with MDMuxread = 1 and MDRin = 0.
  - MDRin goes to 1 only in the `mem_rdy` cycle; T2 follows.
- Illegal opcode 11111: illegal_op pulses in T3 with all other strobes 0. Next state T0. done stays 0.
- `clear` asserted during T4 of an ADD: all outputs are 0 on the next cycle and `tstate` = 0. With `run` = 0 after a done, the FSM stays in IDLE.

Source files
------------

// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: T-state control unit for register-to-register ALU instructions
module alu_control_sequencer #(
  parameter bit RESET_PC_HOLD = 1'b0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        MDMuxread,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        ADD,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        AND,
  output logic        OR,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        NEG,
  output logic        NOT,
  output logic        done,
  output logic        illegal_op,
  output logic [3:0]  tstate
);
  typedef enum logic [3:0] {IDLE, T0, T1, T1M, T2, T3, T4, T5, T6} state_t;
  state_t st_q, st_d, bnd;
  logic armed_q, armed_d;
  logic [4:0] opc;
  logic [15:0] ra_oh, rb_oh, rc_oh;
  logic tr, md, un, opx;
  always_comb begin
    opc = ir[31:27];
    ra_oh = 16'(1) << ir[26:23];
    rb_oh = 16'(1) << ir[22:19];
    rc_oh = 16'(1) << ir[18:15];
    tr = opc >= 5'd3 && opc <= 5'd11;
    md = opc == 5'd15 || opc == 5'd16;
    un = opc == 5'd17 || opc == 5'd18;
    done = (st_q == T4 && un) || (st_q == T5 && tr) || (st_q == T6 && md);
    illegal_op = st_q == T3 && !(tr || md || un);
    bnd = run ? T0 : IDLE;
    armed_d = armed_q | run;
    // with the hold option, run must have been seen in an earlier cycle after clear
    st_d = st_q == IDLE ? ((run && (!RESET_PC_HOLD || armed_q)) ? T0 : IDLE) :
           st_q == T0 ? T1 :
           st_q == T1 ? T1M :
           st_q == T1M ? (mem_rdy ? T2 : T1M) :
           st_q == T2 ? T3 :
           (done || illegal_op) ? bnd :
           st_q == T3 ? T4 :
           st_q == T4 ? T5 :
           st_q == T5 ? T6 : IDLE;
    PCout = st_q == T0;
    MARin = st_q == T0;
    IncPC = st_q == T0;
    PCin = st_q == T1;
    MDMuxread = st_q == T1M;
    MDRin = st_q == T1M && mem_rdy;
    MDRout = st_q == T2;
    IRin = st_q == T2;
    Yin = st_q == T3 && (tr || md);
    Zlowin = st_q == T0 || (st_q == T3 && un) || (st_q == T4 && (tr || md));
    Zhighin = st_q == T4 && md;
    Zlowout = st_q == T1 || (st_q == T4 && un) || (st_q == T5 && (tr || md));
    Zhighout = st_q == T6 && md;
    HIin = st_q == T6 && md;
    LOin = st_q == T5 && md;
    Rout = (st_q == T3 && (tr || un)) ? rb_oh :
           (st_q == T3 && md) ? ra_oh :
           (st_q == T4 && tr) ? rc_oh :
           (st_q == T4 && md) ? rb_oh : 16'h0;
    Rin = ((st_q == T4 && un) || (st_q == T5 && tr)) ? ra_oh : 16'h0;
    opx = (st_q == T3 && un) || (st_q == T4 && (tr || md));
    ADD = opx && opc == 5'd3;
    SUB = opx && opc == 5'd4;
    AND = opx && opc == 5'd5;
    OR = opx && opc == 5'd6;
    ROR = opx && opc == 5'd7;
    ROL = opx && opc == 5'd8;
    SHR = opx && opc == 5'd9;
    SHRA = opx && opc == 5'd10;
    SHL = opx && opc == 5'd11;
    DIV = opx && opc == 5'd15;
    MUL = opx && opc == 5'd16;
    NEG = opx && opc == 5'd17;
    NOT = opx && opc == 5'd18;
    tstate = st_q;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      st_q <= IDLE;
      armed_q <= 1'b0;
    end else begin
      st_q <= st_d;
      armed_q <= armed_d;
    end
  end
endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb_alu_control_sequencer: directed T-state walk through fetch, ALU classes, waits, illegal op and clear
module tb_alu_control_sequencer;
  logic clock = 1'b0, clear, run, mem_rdy;
  logic [31:0] ir;
  logic PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
  logic Zlowout, Zhighout, HIin, LOin, done, illegal_op;
  logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic [15:0] Rin, Rout;
  logic [3:0] tstate;
  int n_chk = 0, n_err = 0;

  localparam logic [16:0] S_PCOUT = 17'h10000, S_MARIN = 17'h08000, S_INCPC = 17'h04000,
    S_PCIN = 17'h02000, S_MDMUX = 17'h01000, S_MDRIN = 17'h00800, S_MDROUT = 17'h00400,
    S_IRIN = 17'h00200, S_YIN = 17'h00100, S_ZLIN = 17'h00080, S_ZHIN = 17'h00040,
    S_ZLOUT = 17'h00020, S_ZHOUT = 17'h00010, S_HIIN = 17'h00008, S_LOIN = 17'h00004,
    S_DONE = 17'h00002, S_ILL = 17'h00001;
  localparam logic [12:0] O_ADD = 13'h1000, O_SUB = 13'h0800, O_MUL = 13'h0400, O_NOT = 13'h0001;

  logic [16:0] strb;
  logic [12:0] ops;
  assign strb = {PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin, Zlowin,
                 Zhighin, Zlowout, Zhighout, HIin, LOin, done, illegal_op};
  assign ops = {ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT};

  alu_control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_rdy(mem_rdy),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .MDMuxread(MDMuxread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
    .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA),
    .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
    .done(done), .illegal_op(illegal_op), .tstate(tstate)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // check one state cycle at the falling edge, then move just past the next rising edge
  task automatic cyc(input string tag, input logic [3:0] t, input logic [16:0] s,
                     input logic [12:0] o, input logic [15:0] ri, input logic [15:0] ro);
    @(negedge clock);
    chk({tag, ".tstate"}, 32'(tstate), 32'(t));
    chk({tag, ".strobes"}, 32'(strb), 32'(s));
    chk({tag, ".ops"}, 32'(ops), 32'(o));
    chk({tag, ".Rin"}, 32'(Rin), 32'(ri));
    chk({tag, ".Rout"}, 32'(Rout), 32'(ro));
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, ".T0"}, 4'd1, S_PCOUT | S_MARIN | S_INCPC | S_ZLIN, 13'h0, 16'h0, 16'h0);
    cyc({tag, ".T1"}, 4'd2, S_ZLOUT | S_PCIN, 13'h0, 16'h0, 16'h0);
    cyc({tag, ".T1M"}, 4'd3, S_MDMUX | S_MDRIN, 13'h0, 16'h0, 16'h0);
    cyc({tag, ".T2"}, 4'd4, S_MDROUT | S_IRIN, 13'h0, 16'h0, 16'h0);
  endtask

  initial begin
    clear = 1'b1; run = 1'b0; mem_rdy = 1'b1; ir = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    cyc("reset", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    clear = 1'b0; run = 1'b1; ir = 32'h93380000;
    cyc("not.idle", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    fetch("not");
    cyc("not.T3", 4'd5, S_ZLIN, O_NOT, 16'h0, 16'h0080);
    cyc("not.T4", 4'd6, S_ZLOUT | S_DONE, 13'h0, 16'h0040, 16'h0);
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    fetch("add");
    cyc("add.T3", 4'd5, S_YIN, 13'h0, 16'h0, 16'h0004);
    cyc("add.T4", 4'd6, S_ZLIN, O_ADD, 16'h0, 16'h0008);
    cyc("add.T5", 4'd7, S_ZLOUT | S_DONE, 13'h0, 16'h0002, 16'h0);
    ir = {5'b10000, 4'd4, 4'd5, 4'd0, 15'd0};
    fetch("mul");
    cyc("mul.T3", 4'd5, S_YIN, 13'h0, 16'h0, 16'h0010);
    cyc("mul.T4", 4'd6, S_ZLIN | S_ZHIN, O_MUL, 16'h0, 16'h0020);
    cyc("mul.T5", 4'd7, S_ZLOUT | S_LOIN, 13'h0, 16'h0, 16'h0);
    cyc("mul.T6", 4'd8, S_ZHOUT | S_HIIN | S_DONE, 13'h0, 16'h0, 16'h0);
    ir = {5'b00100, 4'd8, 4'd9, 4'd10, 15'd0};
    mem_rdy = 1'b0;
    cyc("wait.T0", 4'd1, S_PCOUT | S_MARIN | S_INCPC | S_ZLIN, 13'h0, 16'h0, 16'h0);
    cyc("wait.T1", 4'd2, S_ZLOUT | S_PCIN, 13'h0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) cyc($sformatf("wait.hold%0d", i), 4'd3, S_MDMUX, 13'h0, 16'h0, 16'h0);
    mem_rdy = 1'b1;
    cyc("wait.T1M", 4'd3, S_MDMUX | S_MDRIN, 13'h0, 16'h0, 16'h0);
    cyc("wait.T2", 4'd4, S_MDROUT | S_IRIN, 13'h0, 16'h0, 16'h0);
    cyc("sub.T3", 4'd5, S_YIN, 13'h0, 16'h0, 16'h0200);
    cyc("sub.T4", 4'd6, S_ZLIN, O_SUB, 16'h0, 16'h0400);
    cyc("sub.T5", 4'd7, S_ZLOUT | S_DONE, 13'h0, 16'h0100, 16'h0);
    ir = {5'b11111, 27'd0};
    fetch("ill");
    cyc("ill.T3", 4'd5, S_ILL, 13'h0, 16'h0, 16'h0);
    ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
    fetch("clr");
    cyc("clr.T3", 4'd5, S_YIN, 13'h0, 16'h0, 16'h0004);
    clear = 1'b1;
    cyc("clr.T4", 4'd6, S_ZLIN, O_ADD, 16'h0, 16'h0008);
    clear = 1'b0; run = 1'b0;
    cyc("clr.idle0", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    cyc("clr.idle1", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    run = 1'b1; ir = 32'h93380000;
    cyc("park.idle", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    cyc("park.T0", 4'd1, S_PCOUT | S_MARIN | S_INCPC | S_ZLIN, 13'h0, 16'h0, 16'h0);
    run = 1'b0;
    cyc("park.T1", 4'd2, S_ZLOUT | S_PCIN, 13'h0, 16'h0, 16'h0);
    cyc("park.T1M", 4'd3, S_MDMUX | S_MDRIN, 13'h0, 16'h0, 16'h0);
    cyc("park.T2", 4'd4, S_MDROUT | S_IRIN, 13'h0, 16'h0, 16'h0);
    cyc("park.T3", 4'd5, S_ZLIN, O_NOT, 16'h0, 16'h0080);
    cyc("park.T4", 4'd6, S_ZLOUT | S_DONE, 13'h0, 16'h0040, 16'h0);
    cyc("park.idle0", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    cyc("park.idle1", 4'd0, 17'h0, 13'h0, 16'h0, 16'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
